// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and helpers for the ALU and the arbiter in front of it.
package alu_pkg;
  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 3'b101;

  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic [31:0]         a;
    logic [31:0]         b;
  } alu_req_t;

  function automatic logic is_valid_op(input logic [ALU_OP_W-1:0] op);
    return op <= ALU_SRA;
  endfunction
endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; shifts consume the whole of B, so amounts >= 32 saturate.
module alu
  import alu_pkg::*;
(
  input  logic [31:0]         A,
  input  logic [31:0]         B,
  input  logic [ALU_OP_W-1:0] ALUOp,
  output logic [31:0]         C
);
  logic big_shamt;
  assign big_shamt = |B[31:5];

  always_comb begin
    C = '0;
    case (ALUOp)
      ALU_ADD: C = A + B;
      ALU_SUB: C = A - B;
      ALU_AND: C = A & B;
      ALU_OR:  C = A | B;
      ALU_SRL: C = big_shamt ? '0 : A >> B[4:0];
      ALU_SRA: C = big_shamt ? {32{A[31]}} : 32'($signed(A) >>> B[4:0]);
      default: C = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for a single shared ALU with a one-entry result slot.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [ALU_OP_W-1:0] req_op0,
  input  logic [ALU_OP_W-1:0] req_op1,
  input  logic [31:0]         req_a0,
  input  logic [31:0]         req_a1,
  input  logic [31:0]         req_b0,
  input  logic [31:0]         req_b1,
  input  logic [TAG_W-1:0]    req_tag0,
  input  logic [TAG_W-1:0]    req_tag1,
  output logic [1:0]          resp_valid,
  input  logic [1:0]          resp_ready,
  output logic [31:0]         resp_data,
  output logic [TAG_W-1:0]    resp_tag,
  output logic                resp_err,
  output logic [CNT_W-1:0]    ops_done
);
  logic             full_q, full_d;
  logic             owner_q, owner_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [31:0]      data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             win, slot_avail, accept, drain;
  alu_req_t         sel;
  logic [TAG_W-1:0] sel_tag;
  logic [31:0]      alu_c;

  // Contention goes to rr_ptr; otherwise whichever single port is valid.
  assign win        = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];
  assign drain      = full_q & resp_ready[owner_q];
  assign slot_avail = ~full_q | resp_ready[owner_q];
  assign req_ready  = (rst_n && slot_avail && |req_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign accept     = |req_ready;

  always_comb begin
    sel     = win ? '{op: req_op1, a: req_a1, b: req_b1} : '{op: req_op0, a: req_a0, b: req_b0};
    sel_tag = win ? req_tag1 : req_tag0;
  end

  alu u_alu (
    .A     (sel.a),
    .B     (sel.b),
    .ALUOp (sel.op),
    .C     (alu_c)
  );

  always_comb begin
    full_d   = full_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    tag_d    = tag_q;
    err_d    = err_q;
    cnt_d    = drain ? cnt_q + CNT_W'(1) : cnt_q;
    if (accept) begin
      // A drain in the same cycle is absorbed: the slot simply reloads.
      full_d   = 1'b1;
      owner_d  = win;
      rr_ptr_d = ~win;
      err_d    = ~is_valid_op(sel.op);
      data_d   = is_valid_op(sel.op) ? alu_c : '0;
      tag_d    = sel_tag;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= 1'b0;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      data_q   <= '0;
      tag_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      full_q   <= full_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign resp_valid = full_q ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign resp_data  = data_q;
  assign resp_tag   = tag_q;
  assign resp_err   = err_q;
  assign ops_done   = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
  localparam int TAG_W = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [2:0]       req_op0 = '0, req_op1 = '0;
  logic [31:0]      req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
  logic [TAG_W-1:0] req_tag0 = '0, req_tag1 = '0;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready = '0;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_err;
  logic [CNT_W-1:0] ops_done;

  always #5 clk = ~clk;

  alu_arbiter #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1), .req_tag0(req_tag0), .req_tag1(req_tag1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err), .ops_done(ops_done)
  );

  // Model: one pending result, the port that has priority, and a handshake total.
  bit          m_full, m_owner, m_err, m_prio;
  logic [31:0] m_data;
  logic [3:0]  m_tag;
  int          m_cnt;
  bit          last_acc, last_win;
  int          n_checks = 0, n_err = 0;

  function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    s = (b > 32'd31) ? 32 : b;
    case (op)
      3'd0: return {1'b0, a + b};
      3'd1: return {1'b0, a - b};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, (s == 32) ? 32'h0 : (a >> s)};
      3'd5: begin
        if (s == 32) return {1'b0, {32{a[31]}}};
        return {1'b0, (a >> s) | (a[31] ? ~(ones >> s) : 32'h0)};
      end
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_owner = 0; m_err = 0; m_prio = 0; m_data = '0; m_tag = '0; m_cnt = 0;
  endtask

  task automatic set_req(input bit p, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag);
    if (p) begin req_op1 = op; req_a1 = a; req_b1 = b; req_tag1 = tag; end
    else begin req_op0 = op; req_a0 = a; req_b0 = b; req_tag0 = tag; end
  endtask

  // One clock: check outputs at the falling edge, advance the model, land just after the rising edge.
  task automatic step();
    bit avail, w;
    logic [1:0] er;
    logic [32:0] r;
    @(negedge clk);
    avail = !m_full || resp_ready[m_owner];
    w = (req_valid == 2'b11) ? m_prio : req_valid[1];
    er = (avail && |req_valid) ? (2'b01 << w) : 2'b00;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("resp_valid", 32'(resp_valid), m_full ? 32'(2'b01 << m_owner) : 32'h0);
    if (m_full) begin
      chk("resp_data", resp_data, m_data);
      chk("resp_tag", 32'(resp_tag), 32'(m_tag));
      chk("resp_err", 32'(resp_err), 32'(m_err));
    end
    chk("ops_done", 32'(ops_done), 32'(m_cnt % 16));
    if (m_full && resp_ready[m_owner]) begin m_cnt++; m_full = 0; end
    if (|er) begin
      r = w ? ref_alu(req_op1, req_a1, req_b1) : ref_alu(req_op0, req_a0, req_b0);
      m_full = 1; m_owner = w; m_data = r[31:0]; m_err = r[32];
      m_tag = w ? req_tag1 : req_tag0;
      m_prio = !w;
    end
    last_acc = |er; last_win = w;
    @(posedge clk); #1;
  endtask

  initial begin
    model_reset();
    // Reset state with both ports requesting.
    req_valid = 2'b11;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(resp_valid), 32'h0);
    chk("rst_data", resp_data, 32'h0);
    chk("rst_ops", 32'(ops_done), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single add on port 0.
    req_valid = 2'b01; resp_ready = 2'b11;
    set_req(0, 3'b000, 32'd5, 32'd7, 4'd3);
    step();
    chk("single_valid", 32'(resp_valid), 32'h1);
    chk("single_data", resp_data, 32'd12);
    chk("single_tag", 32'(resp_tag), 32'd3);
    req_valid = 2'b00;
    step();
    chk("single_ops", 32'(ops_done), 32'd1);

    // Reset while a result is waiting.
    req_valid = 2'b10; resp_ready = 2'b00;
    set_req(1, 3'b011, 32'hF0, 32'h0F, 4'd9);
    step();
    req_valid = 2'b11;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(resp_valid), 32'h0);
    chk("midrst_ops", 32'(ops_done), 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;

    // Contention: grants alternate starting from port 0.
    resp_ready = 2'b11;
    set_req(0, 3'b001, 32'd1, 32'd2, 4'd1);
    set_req(1, 3'b101, 32'h8000_0000, 32'd4, 4'd2);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("grant_seq", 32'(last_win), 32'(i % 2));
      chk("cont_data", resp_data, (i % 2) ? 32'hF800_0000 : 32'hFFFF_FFFF);
    end
    req_valid = 2'b00;
    step();

    // Backpressure on port 1's result.
    req_valid = 2'b10;
    set_req(1, 3'b000, 32'd10, 32'd20, 4'd5);
    step();
    req_valid = 2'b11; resp_ready = 2'b01;
    set_req(0, 3'b010, 32'hFF00, 32'h0FF0, 4'd6);
    set_req(1, 3'b011, 32'h1, 32'h2, 4'd7);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_data", resp_data, 32'd30);
      chk("bp_hold_valid", 32'(resp_valid), 32'h2);
    end
    resp_ready = 2'b10;
    step();
    chk("bp_drain_acc", 32'(last_acc), 32'h1);
    chk("bp_next_data", resp_data, 32'h0F00);
    req_valid = 2'b00; resp_ready = 2'b11;
    step();

    // Illegal op and saturating shifts on port 0.
    req_valid = 2'b01;
    set_req(0, 3'b110, 32'd9, 32'd9, 4'd1);
    step();
    chk("illegal_data", resp_data, 32'h0);
    chk("illegal_err", 32'(resp_err), 32'h1);
    set_req(0, 3'b100, 32'hFFFF_FFFF, 32'd32, 4'd2);
    step();
    chk("srl32", resp_data, 32'h0);
    chk("srl32_err", 32'(resp_err), 32'h0);
    set_req(0, 3'b101, 32'h8000_0000, 32'd40, 4'd3);
    step();
    chk("sra40", resp_data, 32'hFFFF_FFFF);
    req_valid = 2'b00;
    step();

    // Randomized traffic; an unaccepted request is held stable.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req_valid[p] || (last_acc && last_win == p[0])) begin
          req_valid[p] = ($urandom_range(0, 2) != 0);
          set_req(p[0], 3'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40)),
                  4'($urandom_range(0, 15)));
        end
      end
      resp_ready = 2'($urandom_range(0, 3));
      step();
    end

    // Counter wrap: 17 handshakes on a 4-bit counter.
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    req_valid = 2'b01; resp_ready = 2'b11;
    for (int i = 0; i < 17; i++) begin
      set_req(0, 3'b000, 32'(i), 32'd1, 4'(i));
      step();
    end
    req_valid = 2'b00;
    step();
    chk("wrap_ops", 32'(ops_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational `alu` datapath between two requesters (port 0, port 1).
- Round-robin arbitration over valid/ready request channels.
- Operands are computed on an accepted request; the result is registered and returned with a tag on the winning requester's response channel.
- Sits between the two issue sources and the shared `alu`; one operation in flight at a time.

Parameters:
- TAG_W, 4: width of the requester-supplied tag echoed with each result.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid[1:0]  in  2  per-requester request valid.
- req_ready[1:0]  out  2  per-requester request ready; at most one bit set.
- req_op0 / req_op1  in  3 each  ALUOp: 000 add, 001 sub, 010 and, 011 or, 100 srl, 101 sra.
- req_a0 / req_a1  in  32 each  operand A.
- req_b0 / req_b1  in  32 each  operand B.
- req_tag0 / req_tag1  in  TAG_W each  request tag.
- resp_valid[1:0]  out  2  per-requester result valid; at most one bit set.
- resp_ready[1:0]  in  2  per-requester result accept.
- resp_data  out  32  result, shared by both response channels.
- resp_tag  out  TAG_W  tag of the returned result.
- resp_err  out  1  set with resp_valid when the op was 110 or 111; resp_data is 0.
- ops_done  out  CNT_W  count of completed response handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous):
  - resp_valid=00, resp_data=0, resp_tag=0, resp_err=0, ops_done=0.
  - rr_ptr=0, meaning port 0 has priority.
  - The result slot is emptied; an in-flight result is discarded.
  - req_ready is 00 while rst_n is low.
- Slot state: one result register, states EMPTY and FULL, plus an owner bit.
- Slot availability: slot_avail = EMPTY, or (FULL and resp_ready[owner]).
- Grant (combinational):
  - Only one port valid: that port wins.
  - Both valid: port rr_ptr wins.
  - req_ready[w] = slot_avail & req_valid[w]. req_ready never depends on the other port's ready.
- Accept (req_valid[w] & req_ready[w] at edge N):
  - The ALU result of port w's op, a and b is registered at edge N.
  - From cycle N+1: resp_valid[w]=1, resp_data, resp_tag, resp_err, owner=w. Latency is 1 cycle.
  - rr_ptr <= ~w.
- Response hold: resp_valid, resp_data, resp_tag and resp_err stay stable until resp_ready[owner]=1. resp_ready of the non-owner port is ignored.
- Drain plus accept in the same cycle: the slot reloads with the new result and stays FULL. Back-to-back throughput is 1 op/cycle.
- Drain with no accept: the slot goes EMPTY and resp_valid goes to 00.
- ops_done increments on every response handshake, including error responses. It wraps from all-ones to 0.
- Arithmetic:
  - add and sub are 32-bit modulo; no carry or overflow output.
  - Shifts use the full 32-bit B. srl with B>=32 gives 0. sra with B>=32 gives 32 copies of A[31].
  - Shift results are identical to the `alu` block.
- Requesters must hold a request stable while valid and not ready; the arbiter does not check this.
- Stalled winner with no handshake: rr_ptr is unchanged, so the granted port keeps its grant while slot_avail=0.

Decomposition:
- Shared package `alu_pkg`: ALUOp localparams ALU_ADD..ALU_SRA, plus ALU_OP_W=3.
- Package predicate: is_valid_op(op) = op <= 3'b101.
- One sub-module: the existing `alu` (A, B, ALUOp, C), instantiated once and fed by a 2:1 mux on the grant.
- Arbitration, the slot register and the counter stay in alu_arbiter.

Test Plan:
- Reset mid-operation: accept an op, pull rst_n low before resp_ready, release → resp_valid=00, ops_done=0, port 0 has priority.
- Single request: port 0 sends add, a=5, b=7, tag=3, resp_ready=1 → at N+1 resp_valid=01, resp_data=12, resp_tag=3; ops_done=1.
- Contention: both ports valid continuously, resp_ready=11 → grants alternate 0,1,0,1, one per cycle.
  - Port 0: sub 1-2 → 0xFFFFFFFF.
  - Port 1: sra 0x80000000 by 4 → 0xF8000000.
- Backpressure: resp_ready[1]=0 for 3 cycles after a port-1 result → req_ready=00 and outputs stable for those cycles; drain cycle accepts the next request; no result lost.
- Illegal op and edge shifts:
  - op=110, a=9, b=9 → resp_data=0, resp_err=1.
  - srl 0xFFFFFFFF by 32 → 0.
  - sra 0x80000000 by 40 → 0xFFFFFFFF.
- Counter wrap: with CNT_W=4, run 17 handshakes → ops_done = 1.
